// File: rtl/mhsa_sram_arbiter.sv
// Round-robin arbiter sharing one SRAM port among N_REQ requesters.
// Registers the SRAM pins and routes each read response back to its issuing port.
`timescale 1ns/1ps
module mhsa_sram_arbiter #(
    parameter int WIDTH  = 64,
    parameter int LENGTH = 4096,
    parameter int N_REQ  = 3,
    parameter int RD_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   arb_en,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ-1:0]       req_write,
    input  logic [N_REQ*32-1:0]    req_addr,
    input  logic [N_REQ*WIDTH-1:0] req_wdata,
    output logic [N_REQ-1:0]       req_ready,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]       rsp_data,
    output logic                   busy,
    output logic                   addr_err,
    output logic                   acc_write_en,
    output logic [WIDTH-1:0]       acc_data_in,
    output logic [31:0]            acc_addr,
    input  logic [WIDTH-1:0]       acc_data_out
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int PW    = IDX_W + 1;
    localparam int DEPTH = RD_LAT + 1;

    logic [IDX_W-1:0]             rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0]             cand;
    logic                         grant_found;
    logic [IDX_W-1:0]             grant_idx;
    logic [PW-1:0]                pos;
    logic [31:0]                  win_addr;
    logic [WIDTH-1:0]             win_wdata;
    logic                         win_write;
    logic                         win_oob;

    logic                         acc_write_en_q, acc_write_en_d;
    logic [31:0]                  acc_addr_q, acc_addr_d;
    logic [WIDTH-1:0]             acc_data_in_q, acc_data_in_d;
    logic                         addr_err_q, addr_err_d;

    logic [DEPTH-1:0]             pv_q, pv_d;
    logic [DEPTH-1:0]             poob_q, poob_d;
    logic [DEPTH-1:0][IDX_W-1:0]  pport_q, pport_d;

    logic [N_REQ-1:0]             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]             rsp_data_q, rsp_data_d;

    assign cand = (rst_n && arb_en) ? req_valid : '0;

    // Scan from rr_ptr upward with wrap; pos never exceeds 2*N_REQ-2 so PW bits suffice.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        pos         = '0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = PW'(rr_ptr_q) + PW'(k);
            if (pos >= PW'(N_REQ)) begin
                pos = pos - PW'(N_REQ);
            end
            if (!grant_found && cand[pos[IDX_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = pos[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        win_addr  = '0;
        win_wdata = '0;
        win_write = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                win_addr  = req_addr[i*32 +: 32];
                win_wdata = req_wdata[i*WIDTH +: WIDTH];
                win_write = req_write[i];
            end
        end
    end

    assign win_oob = win_addr >= 32'(LENGTH);

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
        assign req_ready[gi] = grant_found && (grant_idx == IDX_W'(gi));
    end

    // Out-of-range accesses never reach the pins: the last legal address/data stay put.
    always_comb begin
        rr_ptr_d       = rr_ptr_q;
        acc_write_en_d = 1'b0;
        acc_addr_d     = acc_addr_q;
        acc_data_in_d  = acc_data_in_q;
        addr_err_d     = addr_err_q;
        if (grant_found) begin
            rr_ptr_d = (grant_idx == IDX_W'(N_REQ-1)) ? '0 : grant_idx + IDX_W'(1);
            if (win_oob) begin
                addr_err_d = 1'b1;
            end else begin
                acc_write_en_d = win_write;
                acc_addr_d     = win_addr;
                acc_data_in_d  = win_wdata;
            end
        end
    end

    assign pv_d[0]    = grant_found && !win_write;
    assign poob_d[0]  = win_oob;
    assign pport_d[0] = grant_idx;

    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_pipe
        assign pv_d[gi]    = pv_q[gi-1];
        assign poob_d[gi]  = poob_q[gi-1];
        assign pport_d[gi] = pport_q[gi-1];
    end

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rsp
        assign rsp_valid_d[gi] = pv_q[DEPTH-1] && (pport_q[DEPTH-1] == IDX_W'(gi));
    end

    always_comb begin
        rsp_data_d = rsp_data_q;
        if (pv_q[DEPTH-1]) begin
            rsp_data_d = poob_q[DEPTH-1] ? '0 : acc_data_out;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q       <= '0;
            acc_write_en_q <= 1'b0;
            acc_addr_q     <= '0;
            acc_data_in_q  <= '0;
            addr_err_q     <= 1'b0;
            pv_q           <= '0;
            poob_q         <= '0;
            pport_q        <= '0;
            rsp_valid_q    <= '0;
            rsp_data_q     <= '0;
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            acc_write_en_q <= acc_write_en_d;
            acc_addr_q     <= acc_addr_d;
            acc_data_in_q  <= acc_data_in_d;
            addr_err_q     <= addr_err_d;
            pv_q           <= pv_d;
            poob_q         <= poob_d;
            pport_q        <= pport_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_data_q     <= rsp_data_d;
        end
    end

    assign acc_write_en = acc_write_en_q;
    assign acc_addr     = acc_addr_q;
    assign acc_data_in  = acc_data_in_q;
    assign addr_err     = addr_err_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign busy         = |pv_q;

endmodule

// File: tb/tb_mhsa_sram_arbiter.sv
// Bench for mhsa_sram_arbiter: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based reference model.
`timescale 1ns/1ps
module tb_mhsa_sram_arbiter;
    localparam int N      = 3;
    localparam int W      = 64;
    localparam int L      = 4096;
    localparam int RD_LAT = 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           arb_en = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_write = '0;
    logic [N*32-1:0] req_addr = '0;
    logic [N*W-1:0] req_wdata = '0;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_data;
    logic           busy;
    logic           addr_err;
    logic           acc_write_en;
    logic [W-1:0]   acc_data_in;
    logic [31:0]    acc_addr;
    logic [W-1:0]   acc_data_out;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    mhsa_sram_arbiter #(.WIDTH(W), .LENGTH(L), .N_REQ(N), .RD_LAT(RD_LAT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .arb_en       (arb_en),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .busy         (busy),
        .addr_err     (addr_err),
        .acc_write_en (acc_write_en),
        .acc_data_in  (acc_data_in),
        .acc_addr     (acc_addr),
        .acc_data_out (acc_data_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] init_pat(input logic [31:0] a);
        return {a ^ 32'hA5A5_0000, ~a};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
        end
    endtask

    // SRAM behavioural model: unwritten words read back as init_pat(addr).
    logic [63:0]   mem [L];
    logic [L-1:0]  mem_wr;
    logic          mem_clear = 1'b1;
    logic [63:0]   rd_pipe [RD_LAT];

    always @(posedge clk) begin
        if (mem_clear) begin
            mem_wr <= '0;
        end else if (acc_write_en && acc_addr < L) begin
            mem[acc_addr[11:0]]    <= acc_data_in;
            mem_wr[acc_addr[11:0]] <= 1'b1;
        end
        rd_pipe[0] <= (acc_addr < L && !mem_clear && mem_wr[acc_addr[11:0]]) ?
                      mem[acc_addr[11:0]] : init_pat(acc_addr);
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign acc_data_out = rd_pipe[RD_LAT-1];

    // Reference model: expected responses are a queue of {due cycle, port, data}.
    typedef struct {
        int          due;
        int          port;
        logic [63:0] data;
    } rsp_t;

    rsp_t         pend[$];
    rsp_t         ent;
    logic [63:0]  ref_mem [int];
    int           rr = 0;
    logic         model_ok = 1'b0;
    logic [N-1:0] e_rv = '0;
    logic [63:0]  e_rd = '0;
    logic         e_busy = 1'b0;
    logic         e_err = 1'b0;
    logic         e_we = 1'b0;
    logic [31:0]  e_addr = '0;
    logic [63:0]  e_din = '0;
    logic         e_known = 1'b1;

    always @(negedge clk) begin
        int          win;
        logic [N-1:0] e_ready;
        logic [31:0] a;
        logic [63:0] d;
        win = -1;
        if (rst_n && arb_en) begin
            for (int k = 0; k < N; k++) begin
                if (win < 0 && req_valid[(rr + k) % N]) win = (rr + k) % N;
            end
        end
        e_ready = (win >= 0) ? N'(1 << win) : '0;
        if (model_ok) begin
            chk("req_ready", req_ready, e_ready);
            chk("rsp_valid", rsp_valid, e_rv);
            chk("rsp_data", rsp_data, e_rd);
            chk("busy", busy, e_busy);
            chk("addr_err", addr_err, e_err);
            chk("acc_write_en", acc_write_en, e_we);
            if (e_known) begin
                chk("acc_addr", acc_addr, e_addr);
                chk("acc_data_in", acc_data_in, e_din);
            end
        end
        if (!rst_n) begin
            pend.delete();
            rr = 0; e_rv = '0; e_rd = '0; e_busy = 0; e_err = 0;
            e_we = 0; e_addr = '0; e_din = '0; e_known = 1;
            model_ok = 1'b1;
        end else begin
            e_rv = '0;
            if (pend.size() > 0 && pend[0].due == cyc + 1) begin
                e_rv = N'(1 << pend[0].port);
                e_rd = pend[0].data;
                void'(pend.pop_front());
            end
            e_we = 1'b0;
            if (win >= 0) begin
                a  = req_addr[win*32 +: 32];
                d  = req_wdata[win*W +: W];
                rr = (win + 1) % N;
                ent.due  = cyc + 2 + RD_LAT;
                ent.port = win;
                if (a >= L) begin
                    e_err   = 1'b1;
                    e_known = 1'b0;
                    ent.data = '0;
                    if (!req_write[win]) pend.push_back(ent);
                end else begin
                    e_addr  = a;
                    e_din   = d;
                    e_known = 1'b1;
                    e_we    = req_write[win];
                    if (req_write[win]) begin
                        ref_mem[int'(a)] = d;
                    end else begin
                        ent.data = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_pat(a);
                        pend.push_back(ent);
                    end
                end
            end
            e_busy = (pend.size() != 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold a request until granted; returns one cycle after the handshake, request dropped.
    task automatic issue(input int port, input logic wr, input logic [31:0] addr,
                         input logic [63:0] data, output int hs_cyc);
        hs_cyc = -1;
        req_write[port] = wr;
        req_addr[port*32 +: 32] = addr;
        req_wdata[port*W +: W] = data;
        req_valid[port] = 1'b1;
        for (int i = 0; i < 64; i++) begin
            #1;
            if (req_ready[port]) begin
                hs_cyc = cyc;
                tick(1);
                req_valid[port] = 1'b0;
                return;
            end
            tick(1);
        end
        req_valid[port] = 1'b0;
        chk("grant_timeout", 64'(port), 64'hFFFF);
    endtask

    localparam logic [63:0] LIT = 64'hDEADBEEF_00000001;
    logic [N-1:0] rr_exp [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    initial begin
        int hs;
        logic [N-1:0] hs_now;
        rst_n = 1'b0;
        tick(3);
        mem_clear = 1'b0;
        req_valid = 3'b111;
        #1;
        chk("reset_ready", req_ready, 3'b000);
        req_valid = '0;
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_busy", busy, 0);
        chk("reset_addr_err", addr_err, 0);
        chk("reset_acc_we", acc_write_en, 0);
        chk("reset_acc_addr", acc_addr, 0);
        chk("reset_acc_din", acc_data_in, 0);
        rst_n = 1'b1;
        tick(1);

        // Write then read on port 0.
        issue(0, 1'b1, 32'h10, LIT, hs);
        chk("wr_acc_we", acc_write_en, 1);
        chk("wr_acc_addr", acc_addr, 32'h10);
        chk("wr_acc_din", acc_data_in, LIT);
        issue(0, 1'b0, 32'h10, '0, hs);
        tick(1);
        chk("rd_early", rsp_valid, 3'b000);
        tick(1);
        chk("rd_rsp_valid", rsp_valid, 3'b001);
        chk("rd_rsp_data", rsp_data, LIT);
        tick(1);
        chk("rd_pulse_one", rsp_valid, 3'b000);
        chk("rd_data_hold", rsp_data, LIT);

        // Round-robin from reset with all ports requesting.
        rst_n = 1'b0;
        req_write = '0;
        req_addr = {32'd30, 32'd20, 32'd10};
        req_valid = 3'b111;
        tick(1);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("rr_order", req_ready, rr_exp[i]);
            tick(1);
        end
        req_valid = 3'b010;
        #1;
        chk("rr_late_port1", req_ready, 3'b010);
        tick(1);
        req_valid = '0;
        tick(5);

        // Pipelined reads 2,0,1.
        req_addr = {32'd5, 32'd7, 32'd6};
        req_valid = 3'b100;
        tick(1);
        req_valid = 3'b001;
        tick(1);
        req_valid = 3'b010;
        tick(1);
        req_valid = '0;
        chk("pipe_rsp0", rsp_valid, 3'b100);
        chk("pipe_dat0", rsp_data, init_pat(32'd5));
        tick(1);
        chk("pipe_rsp1", rsp_valid, 3'b001);
        chk("pipe_dat1", rsp_data, init_pat(32'd6));
        chk("pipe_busy", busy, 1);
        tick(1);
        chk("pipe_rsp2", rsp_valid, 3'b010);
        chk("pipe_dat2", rsp_data, init_pat(32'd7));
        chk("pipe_busy_end", busy, 0);
        tick(2);

        // Out-of-range write then read on port 1.
        chk("oob_err_before", addr_err, 0);
        issue(1, 1'b1, 32'd4096, 64'h1234, hs);
        chk("oob_err_set", addr_err, 1);
        chk("oob_wr_we", acc_write_en, 0);
        issue(1, 1'b0, 32'd5000, '0, hs);
        chk("oob_rd_we", acc_write_en, 0);
        tick(2);
        chk("oob_rsp_valid", rsp_valid, 3'b010);
        chk("oob_rsp_data", rsp_data, 0);
        tick(2);

        // arb_en gating.
        issue(0, 1'b0, 32'd3, '0, hs);
        arb_en = 1'b0;
        req_addr = {32'd40, 32'd41, 32'd42};
        req_valid = 3'b110;
        #1;
        chk("gate_ready0", req_ready, 3'b000);
        tick(1);
        chk("gate_ready1", req_ready, 3'b000);
        chk("gate_busy", busy, 1);
        tick(1);
        chk("gate_rsp", rsp_valid, 3'b001);
        chk("gate_busy_low", busy, 0);
        chk("gate_ready2", req_ready, 3'b000);
        arb_en = 1'b1;
        #1;
        chk("ungate_port1", req_ready, 3'b010);
        tick(1);
        req_valid = 3'b100;
        #1;
        chk("ungate_port2", req_ready, 3'b100);
        tick(1);
        req_valid = '0;
        tick(5);

        // Reset with a read in flight.
        issue(1, 1'b0, 32'd9, '0, hs);
        rst_n = 1'b0;
        req_addr = {32'd50, 32'd51, 32'd52};
        req_valid = 3'b111;
        #1;
        chk("rst_ready", req_ready, 3'b000);
        tick(1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr_err", addr_err, 0);
        chk("rst_acc_we", acc_write_en, 0);
        chk("rst_acc_addr", acc_addr, 0);
        chk("rst_acc_din", acc_data_in, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_first_grant", req_ready, 3'b001);
        tick(1);
        req_valid = '0;
        chk("rst_no_rsp0", rsp_valid, 0);
        tick(1);
        chk("rst_no_rsp1", rsp_valid, 0);
        tick(5);

        // Randomized traffic; the negedge model checks every cycle.
        for (int n = 0; n < 3000; n++) begin
            for (int p = 0; p < N; p++) begin
                if (!req_valid[p] && $urandom_range(0, 99) < 45) begin
                    req_write[p] = 1'($urandom_range(0, 1));
                    req_addr[p*32 +: 32] = ($urandom_range(0, 24) == 0) ?
                        32'(4096 + $urandom_range(0, 2000)) : 32'($urandom_range(0, 63));
                    req_wdata[p*W +: W] = {$urandom, $urandom};
                    req_valid[p] = 1'b1;
                end
            end
            arb_en = ($urandom_range(0, 9) != 0);
            rst_n  = ($urandom_range(0, 599) != 0);
            #1;
            hs_now = req_valid & req_ready;
            tick(1);
            req_valid = req_valid & ~hs_now;
        end
        rst_n = 1'b1;
        arb_en = 1'b1;
        req_valid = '0;
        tick(10);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

endmodule
